// File: rtl/data_modp_pkg.sv
// Shared types and defaults for the sequential modular reducer.
package data_modp_pkg;

  localparam int unsigned DW_DEF  = 512;
  localparam int unsigned MW_DEF  = 256;
  localparam int unsigned BPC_DEF = 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Counter must be able to hold N = dw/bpc.
  function automatic int unsigned cnt_w(input int unsigned dw, input int unsigned bpc);
    return $clog2(dw / bpc + 1);
  endfunction

endpackage

// File: rtl/data_modp_seq_step.sv
// One restoring-remainder step: shift in a dividend bit, subtract the modulus if it fits.
module modp_step
  import data_modp_pkg::*;
#(
  parameter int unsigned MW = MW_DEF
) (
  input  logic [MW-1:0] r,
  input  logic          din,
  input  logic [MW-1:0] m,
  output logic [MW-1:0] r_next
);

  logic [MW:0]   shifted;
  logic [MW+1:0] diff;

  assign shifted = {r, din};
  assign diff    = {1'b0, shifted} - {2'b00, m};
  // A borrow means shifted < m; since r < m held before, the kept value fits in MW bits.
  assign r_next  = diff[MW+1] ? shifted[MW-1:0] : diff[MW-1:0];

endmodule

// File: rtl/data_modp_seq.sv
// Sequential data_i mod modp_i with fixed DW/BPC-cycle latency, abort and zero-modulus error.
module data_modp_seq
  import data_modp_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned MW  = MW_DEF,
  parameter int unsigned BPC = BPC_DEF
) (
  input  logic          clk_i,
  input  logic          arst_ni,
  input  logic          dstr_i,
  input  logic          abort_i,
  input  logic [DW-1:0] data_i,
  input  logic [MW-1:0] modp_i,
  output logic          dbusy_o,
  output logic          dend_o,
  output logic          derr_o,
  output logic [MW-1:0] dmod_o
);

  localparam int unsigned N  = DW / BPC;
  localparam int unsigned CW = cnt_w(DW, BPC);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state_q, state_next;
  logic [MW-1:0] m_q;
  logic [DW-1:0] q_q;
  logic [MW-1:0] r_q;
  logic [CW-1:0] cnt_q;
  logic          start;
  logic [MW-1:0] r_chain [BPC+1];

  assign start   = (state_q == IDLE) && dstr_i && !abort_i;
  assign dbusy_o = (state_q == RUN);

  assign r_chain[0] = r_q;
  for (genvar g = 0; g < BPC; g++) begin : g_step
    modp_step #(.MW(MW)) u_step (
      .r      (r_chain[g]),
      .din    (q_q[DW-1-g]),
      .m      (m_q),
      .r_next (r_chain[g+1])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!arst_ni) state_q <= IDLE;
    else          state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    unique case (state_q)
      IDLE:    if (start && modp_i != '0) state_next = RUN;
      RUN:     if (abort_i || cnt_q == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      m_q    <= '0;
      q_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      dend_o <= 1'b0;
      derr_o <= 1'b0;
      dmod_o <= '0;
    end else begin
      dend_o <= 1'b0;
      derr_o <= 1'b0;
      if (start) begin
        if (modp_i == '0) begin
          dend_o <= 1'b1;
          derr_o <= 1'b1;
          dmod_o <= '0;
        end else begin
          m_q   <= modp_i;
          q_q   <= data_i;
          r_q   <= '0;
          cnt_q <= '0;
        end
      end else if (state_q == RUN && !abort_i) begin
        r_q   <= r_chain[BPC];
        q_q   <= q_q << BPC;
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          dmod_o <= r_chain[BPC];
          dend_o <= 1'b1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  logic [MW-1:0] model_q;

  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      model_q <= '0;
    end else begin
      if (start && modp_i != '0) model_q <= MW'(data_i % DW'(modp_i));
      if (dend_o && !derr_o)
        assert (dmod_o == model_q)
        else $error("data_modp_seq checker: result %h model %h", dmod_o, model_q);
    end
  end
`endif

endmodule

// File: tb/tb_data_modp_seq.sv
// Directed scoreboard bench for data_modp_seq (BPC=1 wide instance and BPC=4 narrow instance).
module tb_data_modp_seq;

  typedef struct {
    logic [255:0] res;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         arst_n;
  logic         dstr, abort;
  logic [511:0] data;
  logic [255:0] modp;
  logic         dbusy, dend, derr;
  logic [255:0] dmod;

  logic         dstr_b;
  logic [63:0]  data_b;
  logic [31:0]  modp_b;
  logic         dbusy_b, dend_b, derr_b;
  logic [31:0]  dmod_b;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t sb_b[$];

  always #5 clk = ~clk;

  data_modp_seq #(.DW(512), .MW(256), .BPC(1)) u_dut (
    .clk_i(clk), .arst_ni(arst_n), .dstr_i(dstr), .abort_i(abort),
    .data_i(data), .modp_i(modp),
    .dbusy_o(dbusy), .dend_o(dend), .derr_o(derr), .dmod_o(dmod)
  );

  data_modp_seq #(.DW(64), .MW(32), .BPC(4)) u_dut_b (
    .clk_i(clk), .arst_ni(arst_n), .dstr_i(dstr_b), .abort_i(1'b0),
    .data_i(data_b), .modp_i(modp_b),
    .dbusy_o(dbusy_b), .dend_o(dend_b), .derr_o(derr_b), .dmod_o(dmod_b)
  );

  function automatic logic [255:0] model(input logic [511:0] d, input logic [255:0] m);
    logic [511:0] t;
    t = d % {256'b0, m};
    return t[255:0];
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_nopush(input logic [511:0] d, input logic [255:0] m);
    @(negedge clk);
    data = d; modp = m; dstr = 1'b1;
    @(negedge clk);
    dstr = 1'b0;
  endtask

  task automatic do_op(input logic [511:0] d, input logic [255:0] m, input bit now, input bit glitch);
    exp_t e;
    int   lat;
    e.err = (m == '0);
    e.res = e.err ? '0 : model(d, m);
    sb_q.push_back(e);
    if (!now) @(negedge clk);
    data = d; modp = m; dstr = 1'b1;
    @(negedge clk);
    dstr = 1'b0;
    lat = 0;
    while (dend !== 1'b1 && lat < 540) begin
      @(negedge clk);
      lat++;
      if (glitch && lat == 50) begin data = ~d; modp = m ^ 256'h5; dstr = 1'b1; end
      if (glitch && lat == 51) dstr = 1'b0;
    end
    e = sb_q.pop_front();
    chk("dend_seen", 256'(dend), 256'd1);
    chk("latency", 256'(lat), e.err ? 256'd0 : 256'd512);
    chk("dmod", dmod, e.res);
    chk("derr", 256'(derr), 256'(e.err));
    chk("busy_at_end", 256'(dbusy), 256'd0);
  endtask

  task automatic do_op_b(input logic [63:0] d, input logic [31:0] m);
    exp_t e;
    int   lat;
    e.err = 1'b0;
    e.res = model({448'b0, d}, {224'b0, m});
    sb_b.push_back(e);
    @(negedge clk);
    data_b = d; modp_b = m; dstr_b = 1'b1;
    @(negedge clk);
    dstr_b = 1'b0;
    lat = 0;
    while (dend_b !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb_b.pop_front();
    chk("b_latency", 256'(lat), 256'd16);
    chk("b_dmod", 256'(dmod_b), e.res);
    chk("b_derr", 256'(derr_b), 256'd0);
  endtask

  task automatic expect_no_end(input string tag);
    bit saw;
    saw = 1'b0;
    repeat (520) begin
      @(negedge clk);
      if (dend === 1'b1) saw = 1'b1;
    end
    chk(tag, 256'(saw), 256'd0);
  endtask

  initial begin
    logic [511:0] all1;
    logic [255:0] p;
    logic [255:0] prev;

    arst_n = 1'b0; dstr = 1'b0; abort = 1'b0; data = '0; modp = '0;
    dstr_b = 1'b0; data_b = '0; modp_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 256'(dbusy), 256'd0);
    chk("rst_dend", 256'(dend), 256'd0);
    chk("rst_derr", 256'(derr), 256'd0);
    chk("rst_dmod", dmod, 256'd0);
    arst_n = 1'b1;

    do_op(512'd1000, 256'd7, 0, 0);
    chk("t1_result", dmod, 256'd6);
    @(negedge clk);
    chk("t1_pulse", 256'(dend), 256'd0);
    chk("t1_hold", dmod, 256'd6);

    all1 = '1;
    p = '1;
    p = p - 256'd188;
    do_op(all1, p, 0, 0);
    do_op(512'd5, 256'd9, 0, 0);
    chk("t2_small", dmod, 256'd5);
    do_op(512'd0, 256'd12345, 0, 0);
    do_op({256'b0, p}, p, 0, 0);
    chk("t2_equal", dmod, 256'd0);

    do_op(512'd123, 256'd0, 0, 0);

    // Mid-run start pulses with other operands must not disturb the result.
    do_op(512'd123456789, 256'd1000003, 0, 1);
    prev = 256'd123456789 % 256'd1000003;

    start_nopush(all1, 256'd977);
    repeat (99) @(negedge clk);
    chk("abort_busy_before", 256'(dbusy), 256'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy_after", 256'(dbusy), 256'd0);
    chk("abort_no_dend", 256'(dend), 256'd0);
    expect_no_end("abort_silent");
    chk("abort_dmod_kept", dmod, prev);
    do_op(all1, 256'd977, 0, 0);

    start_nopush({256'hdead_beef, 256'h1234_5678}, p);
    repeat (299) @(negedge clk);
    arst_n = 1'b0;
    @(negedge clk);
    chk("mrst_busy", 256'(dbusy), 256'd0);
    chk("mrst_dend", 256'(dend), 256'd0);
    chk("mrst_derr", 256'(derr), 256'd0);
    chk("mrst_dmod", dmod, 256'd0);
    arst_n = 1'b1;
    expect_no_end("mrst_silent");
    do_op({256'hdead_beef, 256'h1234_5678}, p, 0, 0);

    do_op(512'd99991, 256'd97, 0, 0);
    do_op(all1, 256'd65537, 1, 0);

    @(negedge clk);
    data = 512'd42; modp = 256'd5; dstr = 1'b1; abort = 1'b1;
    @(negedge clk);
    dstr = 1'b0; abort = 1'b0;
    chk("idle_abort_blocks", 256'(dbusy), 256'd0);
    chk("idle_abort_no_end", 256'(dend), 256'd0);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] mb;
      mb = $urandom;
      if (mb == '0) mb = 32'd1;
      if (i == 0) mb = 32'hffff_ffff;
      do_op_b({$urandom, $urandom}, mb);
    end
    chk("b_busy_end", 256'(dbusy_b), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
